fixed_range_restoration: RTL and testbench

- Inverse of the MSB range-reduction stage.
- Takes a normalised Q1.(WIDTH-1) mantissa plus the MSB index produced by reduction and shifts the mantissa back into the original Q(INT).(FRAC) frame.
- Used at the tail of normalise → compute → denormalise datapaths (log/sqrt/reciprocal units).
- Two-stage pipeline with valid/ready handshakes, full throughput, optional round-half-up.

---
 rtl/fixed_range_restoration.sv | 97 +++++++++
 tb/tb_fixed_range_restoration.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_range_restoration.sv
// fixed_range_restoration
//   Undoes MSB range reduction: a normalised Q1.(WIDTH-1) mantissa is shifted
//   right by (WIDTH-1-msb_index) to land back in the original fixed-point frame.
//   Two register stages with valid/ready flow control, full throughput.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   data_in           normalised mantissa, Q1.(WIDTH-1)
//   msb_index_in      original MSB position (bit 0 = rightmost)
//   not_found_in      original value was zero -> output 0
//   data_in_valid     upstream beat valid
//   data_in_ready     beat accepted this cycle (combinational from data_out_ready)
//   data_out          restored value
//   data_out_valid    output beat valid
//   data_out_ready    downstream accepts
module fixed_range_restoration #(
  parameter  int WIDTH     = 16,
  parameter  int ROUND     = 0,
  localparam int MSB_WIDTH = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [MSB_WIDTH-1:0] msb_index_in,
  input  logic                 not_found_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam logic [MSB_WIDTH-1:0] IDX_MAX = MSB_WIDTH'(WIDTH-1);

  logic                 v1, v2;
  logic                 adv1, adv2;
  logic [MSB_WIDTH-1:0] idx_c;
  logic [WIDTH-1:0]     d1;
  logic [MSB_WIDTH-1:0] shamt1;
  logic                 nf1;
  logic [WIDTH-1:0]     shifted;
  logic                 rbit;
  logic [WIDTH-1:0]     res;

  // flow control: a stage advances when empty or when the stage after it drains
  assign adv2           = !v2 || data_out_ready;
  assign adv1           = !v1 || adv2;
  assign data_in_ready  = adv1;
  assign data_out_valid = v2;

  // index clamp only exists when WIDTH leaves unused index codes
  generate
    if ((1 << MSB_WIDTH) == WIDTH) begin : g_no_clamp
      assign idx_c = msb_index_in;
    end else begin : g_clamp
      assign idx_c = (msb_index_in > IDX_MAX) ? IDX_MAX : msb_index_in;
    end
  endgenerate

  // S1 data: no reset needed, qualified by v1
  always_ff @(posedge clk) begin
    if (adv1 && data_in_valid) begin
      d1     <= data_in;
      shamt1 <= IDX_MAX - idx_c;
      nf1    <= not_found_in;
    end
  end

  // S2 combinational: shift back, optional round-half-up on first dropped bit.
  // The mantissa is < 2^WIDTH, so shifted+1 stays <= 2^(WIDTH-1): no overflow.
  always_comb begin
    shifted = d1 >> shamt1;
    rbit    = 1'b0;
    if (ROUND != 0 && shamt1 != '0)
      rbit = d1[shamt1 - MSB_WIDTH'(1)];
    res = shifted + {{(WIDTH-1){1'b0}}, rbit};
    if (nf1)
      res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      data_out <= '0;
    end else begin
      if (adv1)
        v1 <= data_in_valid;
      if (adv2) begin
        v2 <= v1;
        if (v1)
          data_out <= res;
      end
    end
  end

endmodule

// File: tb/tb_fixed_range_restoration.sv
// Bench for fixed_range_restoration: two instances (truncate / round) share
// one stimulus stream. Directed table, back-to-back, backpressure, mid-op
// reset and a random reduction->restoration round trip.
module tb_fixed_range_restoration;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  idx;
  logic        nf;
  logic        in_valid;
  logic        out_ready;
  logic        rdy0, rdy1, ov0, ov1;
  logic [15:0] dout0, dout1;

  always #5 clk = ~clk;

  fixed_range_restoration #(.WIDTH(16), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(din), .msb_index_in(idx), .not_found_in(nf),
    .data_in_valid(in_valid), .data_in_ready(rdy0), .data_out(dout0),
    .data_out_valid(ov0), .data_out_ready(out_ready));

  fixed_range_restoration #(.WIDTH(16), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(din), .msb_index_in(idx), .not_found_in(nf),
    .data_in_valid(in_valid), .data_in_ready(rdy1), .data_out(dout1),
    .data_out_valid(ov1), .data_out_ready(out_ready));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // independent reference: add half-LSB in wide arithmetic then shift
  function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] i,
                                        input logic n, input bit rnd);
    int          sh;
    logic [16:0] acc;
    sh  = 15 - int'(i);
    acc = {1'b0, d};
    if (rnd && sh > 0) acc = acc + (17'(1) << (sh - 1));
    if (n) return 16'h0000;
    return 16'(acc >> sh);
  endfunction

  typedef struct {
    logic [15:0] d;
    logic [3:0]  i;
    logic        n;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
  } exp_t;

  exp_t        q[$];
  bit          sb_en = 0;
  bit          rt = 0;
  logic [15:0] cur_x;
  int          in_cnt, out_cnt, first_out, last_out;
  int          cyc = 0;
  bit          prev_stall = 0;
  logic [15:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: inputs are driven at posedge+1, so negedge values equal what
  // the next rising edge will see
  always @(negedge clk) begin
    if (rst || !sb_en) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {31'b0, ov0}, 32'd1);
        chk("stall_data_hold", {16'b0, dout0}, {16'b0, held_d});
      end
      prev_stall = ov0 && !out_ready;
      held_d     = dout0;
      if (ov0 && out_ready) begin
        chk("out_valid_pair", {31'b0, ov1}, 32'd1);
        if (q.size() == 0) begin
          chk("unexpected_beat", {16'b0, dout0}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("stream_trunc", {16'b0, dout0}, {16'b0, e.e0});
          chk("stream_round", {16'b0, dout1}, {16'b0, e.e1});
        end
        out_cnt++;
        if (out_cnt == 1) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && rdy0) begin
        exp_t e;
        e.e0 = rt ? cur_x : model(din, idx, nf, 1'b0);
        e.e1 = rt ? cur_x : model(din, idx, nf, 1'b1);
        q.push_back(e);
        in_cnt++;
      end
    end
  end

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((q.size() != 0 || ov0) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", q.size(), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'h8000, 4'd3,  1'b0, 16'h0008, 16'h0008};
    tbl[1] = '{16'hB000, 4'd15, 1'b0, 16'hB000, 16'hB000};
    tbl[2] = '{16'h1234, 4'd5,  1'b1, 16'h0000, 16'h0000};
    tbl[3] = '{16'hC000, 4'd0,  1'b0, 16'h0001, 16'h0002};
    tbl[4] = '{16'hFFFF, 4'd14, 1'b0, 16'h7FFF, 16'h8000};
    tbl[5] = '{16'hA5A5, 4'd7,  1'b0, 16'h00A5, 16'h00A6};
    tbl[6] = '{16'h9000, 4'd10, 1'b0, 16'h0480, 16'h0480};
    tbl[7] = '{16'h8001, 4'd15, 1'b0, 16'h8001, 16'h8001};

    rst = 1; din = 0; idx = 0; nf = 0; in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid0", {31'b0, ov0}, 32'd0);
    chk("rst_valid1", {31'b0, ov1}, 32'd0);
    chk("rst_data0", {16'b0, dout0}, 32'd0);
    chk("rst_ready", {31'b0, rdy0}, 32'd1);

    // directed table, exact two-cycle latency
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      din = tbl[i].d; idx = tbl[i].i; nf = tbl[i].n; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      chk("lat_not_1", {31'b0, ov0}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_valid", {31'b0, ov0}, 32'd1);
      chk("tbl_trunc", {16'b0, dout0}, {16'b0, tbl[i].e0});
      chk("tbl_round", {16'b0, dout1}, {16'b0, tbl[i].e1});
    end
    @(posedge clk); #1;

    // back-to-back: 8 beats, outputs on 8 consecutive cycles
    sb_en = 1; out_cnt = 0; in_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      din = 16'h8000; idx = 4'(i); nf = 0; in_valid = 1;
    end
    @(posedge clk); #1 in_valid = 0;
    drain(20);
    chk("b2b_count", out_cnt, 32'd8);
    chk("b2b_no_gap", last_out - first_out, 32'd7);

    // backpressure: ready low for 5 cycles while streaming
    @(posedge clk); #1;
    out_ready = 0; in_cnt = 0; out_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      din = 16'h8000 | 16'(k * 16'h0111); idx = 4'(k + 4); nf = 0; in_valid = 1;
    end
    @(negedge clk);
    chk("bp_accepted", in_cnt, 32'd2);
    chk("bp_in_ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    drain(20);
    chk("bp_inorder_cnt", out_cnt, in_cnt);

    // reset with both stages full
    @(posedge clk); #1;
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      din = 16'hC000; idx = 4'(k); in_valid = 1;
    end
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; q.delete();
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, ov0}, 32'd0);
    chk("mid_rst_ready", {31'b0, rdy0}, 32'd1);
    out_ready = 1;
    repeat (5) @(negedge clk);
    chk("mid_rst_quiet", q.size(), 32'd0);

    // random round trip through a reduction model
    begin
      int  sent, iter;
      bit  acc;
      int  hi;
      logic [15:0] x;
      rt = 1; sent = 0; iter = 0; in_cnt = 0; out_cnt = 0;
      @(posedge clk); #1;
      while (sent < 10000 && iter < 60000) begin
        @(negedge clk);
        acc = in_valid && rdy0;
        @(posedge clk); #1;
        iter++;
        if (acc) sent++;
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(3) != 0) && (sent < 10000);
          x  = 16'($urandom_range(1, 65535));
          hi = 0;
          for (int b = 0; b < 16; b++) if (x[b]) hi = b;
          cur_x = x;
          din   = x << (15 - hi);
          idx   = 4'(hi);
          nf    = 0;
        end
        out_ready = ($urandom_range(3) != 0);
      end
      chk("rt_budget", {31'b0, (sent >= 10000)}, 32'd1);
      in_valid = 0; out_ready = 1;
      drain(20);
      chk("rt_count", out_cnt, in_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
